// File: rtl/simple_pkg.sv
// rtl/simple_pkg.sv - shared widths, condition codes, flag indices and branch-condition helper
package simple_pkg;

  localparam int W      = 16;
  localparam int NREG   = 8;
  localparam int REG_AW = $clog2(NREG);

  localparam int FLAG_S = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  typedef enum logic [2:0] {
    COND_BE  = 3'b000,
    COND_BLT = 3'b001,
    COND_BLE = 3'b010,
    COND_BNE = 3'b011,
    COND_B   = 3'b100
  } cond_e;

  // Codes 101-111 are reserved and never take the branch.
  function automatic logic cond_true(input logic [3:0] flags, input logic [2:0] cond);
    logic w_lt;
    w_lt = flags[FLAG_S] ^ flags[FLAG_V];
    case (cond)
      COND_BE:  cond_true = flags[FLAG_Z];
      COND_BLT: cond_true = w_lt;
      COND_BLE: cond_true = flags[FLAG_Z] | w_lt;
      COND_BNE: cond_true = ~flags[FLAG_Z];
      COND_B:   cond_true = 1'b1;
      default:  cond_true = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/writeback_unit_reg_file.sv
// rtl/writeback_unit_reg_file.sv - general register storage, one synchronous write, two combinational reads
module reg_file #(
  parameter int DW = 16,
  parameter int NR = 8,
  parameter int AW = $clog2(NR)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  logic [DW-1:0] i_wdata,
  input  logic [AW-1:0] i_raddr_a,
  input  logic [AW-1:0] i_raddr_b,
  output logic [DW-1:0] o_rdata_a,
  output logic [DW-1:0] o_rdata_b
);

  logic [DW-1:0] r_mem [NR];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NR; i++) r_mem[i] <= '0;
    end else if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata_a = r_mem[i_raddr_a];
  assign o_rdata_b = r_mem[i_raddr_b];

endmodule

// File: rtl/writeback_unit.sv
// rtl/writeback_unit.sv - commit stage: register writeback, flag register, branch resolution, retire count
// Optional WB_BYPASS_EN: forwards the committing alu_res onto a matching read port in the same cycle.
module writeback_unit
  import simple_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              stall,
  input  logic [REG_AW-1:0] rd_addr,
  input  logic              wr_en,
  input  logic [W-1:0]      alu_res,
  input  logic [3:0]        alu_szcv,
  input  logic              set_flags,
  input  logic              is_branch,
  input  logic [2:0]        br_cond,
  input  logic [W-1:0]      br_target,
  input  logic [REG_AW-1:0] ra_addr,
  input  logic [REG_AW-1:0] rb_addr,
  output logic [W-1:0]      ra_data,
  output logic [W-1:0]      rb_data,
  output logic [3:0]        szcv_q,
  output logic              br_taken,
  output logic [W-1:0]      br_pc,
  output logic [15:0]       retire_cnt
);

  logic          w_commit;
  logic          w_taken;
  logic [W-1:0]  w_ra_rf;
  logic [W-1:0]  w_rb_rf;
  logic [3:0]    r_szcv;
  logic          r_br_taken;
  logic [W-1:0]  r_br_pc;
  logic [15:0]   r_retire_cnt;

  assign in_ready = ~stall;
  assign w_commit = in_valid & ~stall;
  // Branch sees the flags as they stood before this commit's own flag update.
  assign w_taken  = w_commit & is_branch & cond_true(r_szcv, br_cond);

  reg_file #(.DW(W), .NR(NREG), .AW(REG_AW)) u_reg_file (
    .clk       (clk),
    .rst       (rst),
    .i_we      (w_commit & wr_en),
    .i_waddr   (rd_addr),
    .i_wdata   (alu_res),
    .i_raddr_a (ra_addr),
    .i_raddr_b (rb_addr),
    .o_rdata_a (w_ra_rf),
    .o_rdata_b (w_rb_rf)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_szcv       <= '0;
      r_br_taken   <= 1'b0;
      r_br_pc      <= '0;
      r_retire_cnt <= '0;
    end else begin
      r_br_taken <= w_taken;
      if (w_taken) r_br_pc <= br_target;
      if (w_commit) begin
        if (set_flags) r_szcv <= alu_szcv;
        r_retire_cnt <= r_retire_cnt + 16'd1;
      end
    end
  end

`ifdef WB_BYPASS_EN
  assign ra_data = (w_commit && wr_en && (rd_addr == ra_addr)) ? alu_res : w_ra_rf;
  assign rb_data = (w_commit && wr_en && (rd_addr == rb_addr)) ? alu_res : w_rb_rf;
`else
  assign ra_data = w_ra_rf;
  assign rb_data = w_rb_rf;
`endif

  assign szcv_q     = r_szcv;
  assign br_taken   = r_br_taken;
  assign br_pc      = r_br_pc;
  assign retire_cnt = r_retire_cnt;

endmodule

// File: tb/tb_writeback_unit.sv
// tb/tb_writeback_unit.sv - directed bench with a branch-outcome scoreboard and a register/flag model
`timescale 1ns/1ps
module tb_writeback_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic        stall;
  logic [2:0]  rd_addr;
  logic        wr_en;
  logic [15:0] alu_res;
  logic [3:0]  alu_szcv;
  logic        set_flags;
  logic        is_branch;
  logic [2:0]  br_cond;
  logic [15:0] br_target;
  logic [2:0]  ra_addr;
  logic [2:0]  rb_addr;
  logic [15:0] ra_data;
  logic [15:0] rb_data;
  logic [3:0]  szcv_q;
  logic        br_taken;
  logic [15:0] br_pc;
  logic [15:0] retire_cnt;

  always #5 clk = ~clk;

  writeback_unit dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .stall(stall),
    .rd_addr(rd_addr), .wr_en(wr_en), .alu_res(alu_res), .alu_szcv(alu_szcv),
    .set_flags(set_flags), .is_branch(is_branch), .br_cond(br_cond), .br_target(br_target),
    .ra_addr(ra_addr), .rb_addr(rb_addr), .ra_data(ra_data), .rb_data(rb_data),
    .szcv_q(szcv_q), .br_taken(br_taken), .br_pc(br_pc), .retire_cnt(retire_cnt)
  );

  typedef struct packed {
    logic        taken;
    logic [15:0] pc;
  } exp_t;

  exp_t        sb[$];
  logic [15:0] m_regs [8];
  logic [3:0]  m_szcv;
  logic [15:0] m_pc;
  logic [15:0] m_cnt;
  int          n_checks = 0;
  int          n_pass   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks = n_checks + 1;
    assert (obs === exp) n_pass = n_pass + 1;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  function automatic logic m_cond(input logic [3:0] f, input logic [2:0] c);
    logic s, z, v;
    s = f[3]; z = f[2]; v = f[0];
    case (c)
      3'd0: return z;
      3'd1: return s ^ v;
      3'd2: return z | (s ^ v);
      3'd3: return !z;
      3'd4: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  task automatic do_commit(input logic we, input logic [2:0] rd, input logic [15:0] res,
                           input logic sf, input logic [3:0] f,
                           input logic br, input logic [2:0] cond, input logic [15:0] tgt);
    exp_t e;
    in_valid = 1'b1; stall = 1'b0; wr_en = we; rd_addr = rd; alu_res = res;
    set_flags = sf; alu_szcv = f; is_branch = br; br_cond = cond; br_target = tgt;
    e.taken = br && m_cond(m_szcv, cond);
    if (e.taken) m_pc = tgt;
    e.pc = m_pc;
    sb.push_back(e);
    if (we) m_regs[rd] = res;
    if (sf) m_szcv = f;
    m_cnt = m_cnt + 16'd1;
    @(posedge clk); #1;
    in_valid = 1'b0; wr_en = 1'b0; set_flags = 1'b0; is_branch = 1'b0;
    if (sb.size() == 0) begin
      chk("scoreboard_nonempty", 32'd0, 32'd1);
    end else begin
      e = sb.pop_front();
      chk("br_taken", {31'd0, br_taken}, {31'd0, e.taken});
      chk("br_pc", {16'd0, br_pc}, {16'd0, e.pc});
    end
    chk("szcv_q", {28'd0, szcv_q}, {28'd0, m_szcv});
    chk("retire_cnt", {16'd0, retire_cnt}, {16'd0, m_cnt});
  endtask

  task automatic chk_reg(input logic [2:0] a);
    ra_addr = a; rb_addr = a; #1;
    chk($sformatf("ra_reg%0d", a), {16'd0, ra_data}, {16'd0, m_regs[a]});
    chk($sformatf("rb_reg%0d", a), {16'd0, rb_data}, {16'd0, m_regs[a]});
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    rst = 1'b1; in_valid = 1'b0; stall = 1'b0; rd_addr = '0; wr_en = 1'b0; alu_res = '0;
    alu_szcv = '0; set_flags = 1'b0; is_branch = 1'b0; br_cond = '0; br_target = '0;
    ra_addr = '0; rb_addr = '0;
    for (int i = 0; i < 8; i++) m_regs[i] = '0;
    m_szcv = '0; m_pc = '0; m_cnt = '0;

    // reset, with a commit attempt that reset must override
    in_valid = 1'b1; wr_en = 1'b1; rd_addr = 3'd1; alu_res = 16'hDEAD; set_flags = 1'b1; alu_szcv = 4'hF;
    repeat (2) @(posedge clk);
    #1;
    in_valid = 1'b0; wr_en = 1'b0; set_flags = 1'b0;
    for (int i = 0; i < 8; i++) chk_reg(i[2:0]);
    chk("rst_szcv", {28'd0, szcv_q}, 32'd0);
    chk("rst_br_taken", {31'd0, br_taken}, 32'd0);
    chk("rst_br_pc", {16'd0, br_pc}, 32'd0);
    chk("rst_retire", {16'd0, retire_cnt}, 32'd0);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;

    // register write then read back
    do_commit(1'b1, 3'd3, 16'h1234, 1'b0, 4'h0, 1'b0, 3'd0, 16'h0);
    chk_reg(3'd3);

    // flags Z, taken BE, then not-taken BNE with br_pc holding
    do_commit(1'b0, 3'd0, 16'h0, 1'b1, 4'b0100, 1'b0, 3'd0, 16'h0);
    do_commit(1'b0, 3'd0, 16'h0, 1'b0, 4'h0, 1'b1, 3'b000, 16'h0040);
    @(posedge clk); #1;
    chk("br_pulse_end", {31'd0, br_taken}, 32'd0);
    do_commit(1'b0, 3'd0, 16'h0, 1'b0, 4'h0, 1'b1, 3'b011, 16'h0080);
    do_commit(1'b0, 3'd0, 16'h0, 1'b0, 4'h0, 1'b1, 3'b010, 16'h0050);
    do_commit(1'b0, 3'd0, 16'h0, 1'b0, 4'h0, 1'b1, 3'b101, 16'h0060);

    // branch uses old flags while the same commit updates them
    do_commit(1'b0, 3'd0, 16'h0, 1'b1, 4'b0000, 1'b0, 3'd0, 16'h0);
    do_commit(1'b0, 3'd0, 16'h0, 1'b1, 4'b1000, 1'b1, 3'b001, 16'h0099);
    do_commit(1'b0, 3'd0, 16'h0, 1'b0, 4'h0, 1'b1, 3'b001, 16'h00A0);
    do_commit(1'b0, 3'd0, 16'h0, 1'b0, 4'h0, 1'b1, 3'b100, 16'h00B0);
    do_commit(1'b0, 3'd0, 16'h0, 1'b0, 4'h0, 1'b1, 3'b000, 16'h00C0);

    // stall blocks commit
    in_valid = 1'b1; stall = 1'b1; wr_en = 1'b1; rd_addr = 3'd5; alu_res = 16'h5555;
    #1;
    chk("stall_in_ready", {31'd0, in_ready}, 32'd0);
    repeat (2) @(posedge clk);
    #1;
    chk_reg(3'd5);
    chk("stall_retire", {16'd0, retire_cnt}, {16'd0, m_cnt});
    stall = 1'b0;
    #1;
    chk("release_in_ready", {31'd0, in_ready}, 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0; wr_en = 1'b0;
    m_regs[5] = 16'h5555; m_cnt = m_cnt + 16'd1;
    chk_reg(3'd5);
    chk("release_retire", {16'd0, retire_cnt}, {16'd0, m_cnt});

    // same-cycle read of a register being written
    do_commit(1'b1, 3'd2, 16'h1111, 1'b0, 4'h0, 1'b0, 3'd0, 16'h0);
    @(negedge clk);
    ra_addr = 3'd2; rb_addr = 3'd3;
    in_valid = 1'b1; wr_en = 1'b1; rd_addr = 3'd2; alu_res = 16'hBEEF;
    #1;
`ifdef WB_BYPASS_EN
    chk("bypass_ra", {16'd0, ra_data}, 32'h0000BEEF);
`else
    chk("bypass_ra", {16'd0, ra_data}, 32'h00001111);
`endif
    chk("bypass_rb_other", {16'd0, rb_data}, 32'h00001234);
    @(posedge clk); #1;
    in_valid = 1'b0; wr_en = 1'b0;
    m_regs[2] = 16'hBEEF; m_cnt = m_cnt + 16'd1;
    chk_reg(3'd2);

    // retire counter wrap
    n = 32'hFFFF - int'(m_cnt);
    in_valid = 1'b1;
    repeat (n) @(posedge clk);
    #1;
    in_valid = 1'b0;
    m_cnt = 16'hFFFF;
    chk("retire_ffff", {16'd0, retire_cnt}, 32'h0000FFFF);
    do_commit(1'b0, 3'd0, 16'h0, 1'b0, 4'h0, 1'b0, 3'd0, 16'h0);
    chk("retire_wrap", {16'd0, retire_cnt}, 32'h00000000);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
